// File: rtl/gray_binarize_adaptive_pkg.sv
// Shared constants for the adaptive gray-to-binary stage: mode codes,
// divider state encoding and the accumulator width helper.
package gray_bin_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'd0,
        MODE_HYST  = 2'd1,
        MODE_ADAPT = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_LOAD = 2'd1,
        DIV_DIV  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    function automatic int sum_w(input int data_w, input int cnt_w);
        return data_w + cnt_w;
    endfunction

endpackage

// File: rtl/gray_binarize_adaptive_if.sv
// Pixel stream and control bus between the grayscale converter, the
// binarizer and the display/storage path.
interface gray_bin_if #(parameter int DATA_W = 10);

    logic              iFVAL;
    logic              iDVAL;
    logic [DATA_W-1:0] iDATA;
    logic [1:0]        iMODE;
    logic [DATA_W-1:0] iTHRESH;
    logic [DATA_W-1:0] iHYST;
    logic              oDVAL;
    logic [DATA_W-1:0] oDATA;
    logic [DATA_W-1:0] oTHRESH;
    logic              oBUSY;

    modport master (
        output iFVAL, iDVAL, iDATA, iMODE, iTHRESH, iHYST,
        input  oDVAL, oDATA, oTHRESH, oBUSY
    );

    modport slave (
        input  iFVAL, iDVAL, iDATA, iMODE, iTHRESH, iHYST,
        output oDVAL, oDATA, oTHRESH, oBUSY
    );

endinterface

// File: rtl/gray_binarize_adaptive_div.sv
// Unsigned restoring divider, one quotient bit per cycle, with start/busy/done
// handshake. A zero divisor returns to idle without producing a result.
module seq_divider_u
    import gray_bin_pkg::*;
#(
    parameter int DIVIDEND_W = 30,
    parameter int DIVISOR_W  = 20,
    parameter int QUOT_W     = 10
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [QUOT_W-1:0]     quotient
);

    localparam int STEP_W = $clog2(DIVIDEND_W + 1);

    div_state_e            state;
    logic [DIVIDEND_W-1:0] quo;
    logic [DIVISOR_W-1:0]  den;
    logic [DIVISOR_W-1:0]  rem;
    logic [STEP_W-1:0]     step;
    logic [DIVISOR_W:0]    rem_shift;
    logic [DIVISOR_W-1:0]  rem_sub;

    // The remainder stays below the divisor, so the low bits of the
    // subtraction are exact whenever the trial subtraction succeeds.
    assign rem_shift = {rem, quo[DIVIDEND_W-1]};
    assign rem_sub   = rem_shift[DIVISOR_W-1:0] - den;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state    <= DIV_IDLE;
            quo      <= '0;
            den      <= '0;
            rem      <= '0;
            step     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        quo   <= dividend;
                        den   <= divisor;
                        rem   <= '0;
                        busy  <= (divisor != '0);
                        state <= DIV_LOAD;
                    end
                end
                DIV_LOAD: begin
                    if (den == '0) begin
                        state <= DIV_IDLE;
                    end else begin
                        step  <= STEP_W'(DIVIDEND_W - 1);
                        state <= DIV_DIV;
                    end
                end
                DIV_DIV: begin
                    if (rem_shift >= {1'b0, den}) begin
                        rem <= rem_sub;
                        quo <= {quo[DIVIDEND_W-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[DIVISOR_W-1:0];
                        quo <= {quo[DIVIDEND_W-2:0], 1'b0};
                    end
                    if (step == '0) begin
                        busy  <= 1'b0;
                        state <= DIV_DONE;
                    end else begin
                        step <= step - STEP_W'(1);
                    end
                end
                DIV_DONE: begin
                    quotient <= quo[QUOT_W-1:0];
                    done     <= 1'b1;
                    state    <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gray_binarize_adaptive.sv
// Gray-to-binary stage with fixed, hysteresis and adaptive (previous-frame
// mean) thresholds; the mean is divided out during vertical blanking.
module gray_binarize_adaptive
    import gray_bin_pkg::*;
#(
    parameter int DATA_W      = 10,
    parameter int CNT_W       = 20,
    parameter int THRESH_INIT = 500
) (
    input logic       iCLK,
    input logic       iRST,
    gray_bin_if.slave bus
);

    localparam int                SUM_W   = sum_w(DATA_W, CNT_W);
    localparam logic [DATA_W-1:0] ONES    = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic              fval_d;
    logic              dval_d;
    logic [1:0]        mode_r;
    logic              hyst_s;
    logic              dval_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] thresh_r;
    logic [DATA_W-1:0] pending;
    logic              pending_valid;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  cnt;

    logic              fval_rise;
    logic              fval_fall;
    logic              dval_rise;
    logic [1:0]        mode_cur;
    logic [DATA_W:0]   hi_sum;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              s_base;
    logic              s_next;
    logic              pix_bit;
    logic [SUM_W-1:0]  sum_base;
    logic [CNT_W-1:0]  cnt_base;

    logic              div_busy;
    logic              div_done;
    logic [DATA_W-1:0] div_quot;

    // A pixel arriving on the frame-start cycle already uses the new mode
    // and fresh accumulators, so those bypass their registers here.
    always_comb begin
        fval_rise = bus.iFVAL & ~fval_d;
        fval_fall = ~bus.iFVAL & fval_d;
        dval_rise = bus.iDVAL & ~dval_d;
        mode_cur  = fval_rise ? bus.iMODE : mode_r;
        sum_base  = fval_rise ? '0 : sum;
        cnt_base  = fval_rise ? '0 : cnt;

        hi_sum = {1'b0, bus.iTHRESH} + {1'b0, bus.iHYST};
        hi     = hi_sum[DATA_W] ? ONES : hi_sum[DATA_W-1:0];
        lo     = (bus.iTHRESH > bus.iHYST) ? (bus.iTHRESH - bus.iHYST) : '0;

        s_base = dval_rise ? 1'b0 : hyst_s;
        s_next = s_base;
        if (!s_base && (bus.iDATA > hi)) begin
            s_next = 1'b1;
        end else if (s_base && (bus.iDATA < lo)) begin
            s_next = 1'b0;
        end

        case (mode_cur)
            MODE_HYST:  pix_bit = s_next;
            MODE_ADAPT: pix_bit = (bus.iDATA > thresh_r);
            default:    pix_bit = (bus.iDATA > bus.iTHRESH);
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fval_d        <= 1'b0;
            dval_d        <= 1'b0;
            mode_r        <= MODE_FIXED;
            hyst_s        <= 1'b0;
            dval_q        <= 1'b0;
            data_q        <= '0;
            thresh_r      <= DATA_W'(THRESH_INIT);
            pending       <= '0;
            pending_valid <= 1'b0;
            sum           <= '0;
            cnt           <= '0;
        end else begin
            fval_d <= bus.iFVAL;
            dval_d <= bus.iDVAL;
            dval_q <= bus.iDVAL;
            data_q <= pix_bit ? ONES : '0;

            if (bus.iDVAL) hyst_s <= s_next;
            if (fval_rise) mode_r <= bus.iMODE;

            if (fval_fall) begin
                sum <= '0;
                cnt <= '0;
            end else if (bus.iFVAL && bus.iDVAL && (cnt_base != CNT_MAX)) begin
                sum <= sum_base + SUM_W'(bus.iDATA);
                cnt <= cnt_base + CNT_W'(1);
            end else begin
                sum <= sum_base;
                cnt <= cnt_base;
            end

            // A result finishing on a frame-start cycle waits for the next frame.
            if (fval_rise && pending_valid) begin
                thresh_r      <= pending;
                pending_valid <= 1'b0;
            end
            if (div_done) begin
                pending       <= div_quot;
                pending_valid <= 1'b1;
            end
        end
    end

    seq_divider_u #(
        .DIVIDEND_W(SUM_W),
        .DIVISOR_W (CNT_W),
        .QUOT_W    (DATA_W)
    ) u_div (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .start   (fval_fall),
        .dividend(sum),
        .divisor (cnt),
        .busy    (div_busy),
        .done    (div_done),
        .quotient(div_quot)
    );

    assign bus.oDVAL   = dval_q;
    assign bus.oDATA   = data_q;
    assign bus.oTHRESH = thresh_r;
    assign bus.oBUSY   = div_busy;

endmodule

// File: tb/tb_gray_binarize_adaptive.sv
// Self-checking bench for gray_binarize_adaptive: table vectors, directed
// adaptive/blanking/reset sequences and randomized frames against a model.
module tb_gray_binarize_adaptive;

    localparam int DATA_W      = 10;
    localparam int CNT_W       = 20;
    localparam int THRESH_INIT = 500;
    localparam int ONES        = 1023;

    typedef struct {
        bit    newFrame;
        bit    newLine;
        int    mode;
        int    thresh;
        int    hyst;
        int    data;
        int    expData;
        string name;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int vectors     = 0;
    int miscompares = 0;
    vec_t tbl[$];

    gray_bin_if #(.DATA_W(DATA_W)) bus();

    gray_binarize_adaptive #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .THRESH_INIT(THRESH_INIT)
    ) dut (
        .iCLK(clk),
        .iRST(rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic addVec(input bit nf, input bit nl, input int m, input int t,
                          input int h, input int d, input int e, input string name);
        vec_t v;
        v = '{nf, nl, m, t, h, d, e, name};
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input int mode);
        bus.iMODE = 2'(mode);
        bus.iFVAL = 1'b1;
        tick();
        bus.iMODE = ~2'(mode);
    endtask

    task automatic pixel(input int d, input int e, input string name);
        bus.iDVAL = 1'b1;
        bus.iDATA = 10'(d);
        tick();
        checkOutput({name, " oDVAL"}, int'(bus.oDVAL), 1);
        checkOutput(name, int'(bus.oDATA), e);
    endtask

    task automatic endLine();
        bus.iDVAL = 1'b0;
        tick();
        checkOutput("oDVAL low after line", int'(bus.oDVAL), 0);
    endtask

    task automatic endFrame();
        bus.iDVAL = 1'b0;
        bus.iFVAL = 1'b0;
        tick();
    endtask

    task automatic doReset();
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
        rst_n = 1'b0;
        idle(2);
        checkOutput("reset oDVAL", int'(bus.oDVAL), 0);
        checkOutput("reset oDATA", int'(bus.oDATA), 0);
        checkOutput("reset oBUSY", int'(bus.oBUSY), 0);
        checkOutput("reset oTHRESH", int'(bus.oTHRESH), THRESH_INIT);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int busyLen;
        int firstBusy;
        int dev;
        int thrModel;
        int fsum, fcnt, m, em, t, h, nLines, nPix, d, e, s, hi, lo;

        bus.iFVAL   = 1'b0;
        bus.iDVAL   = 1'b0;
        bus.iDATA   = '0;
        bus.iMODE   = '0;
        bus.iTHRESH = 10'd500;
        bus.iHYST   = '0;
        doReset();

        // Fixed, mode 3, hysteresis and saturation vectors.
        addVec(1, 0, 0, 500, 0, 499, 0, "fix 499");
        addVec(0, 0, 0, 500, 0, 500, 0, "fix 500");
        addVec(0, 0, 0, 500, 0, 501, ONES, "fix 501");
        addVec(0, 0, 0, 500, 0, 1023, ONES, "fix 1023");
        addVec(1, 0, 3, 500, 0, 501, ONES, "mode3 501");
        addVec(0, 0, 3, 500, 0, 500, 0, "mode3 500");
        addVec(1, 0, 1, 500, 20, 515, 0, "hyst 515");
        addVec(0, 0, 1, 500, 20, 521, ONES, "hyst 521");
        addVec(0, 0, 1, 500, 20, 490, ONES, "hyst 490");
        addVec(0, 0, 1, 500, 20, 481, ONES, "hyst 481");
        addVec(0, 0, 1, 500, 20, 479, 0, "hyst 479");
        addVec(0, 0, 1, 500, 20, 521, ONES, "hyst 521b");
        addVec(0, 1, 1, 500, 20, 510, 0, "hyst newline 510");
        addVec(0, 1, 1, 1010, 20, 1023, 0, "hyst hi saturate");
        addVec(0, 1, 1, 10, 20, 31, ONES, "hyst set low band");
        addVec(0, 0, 1, 10, 20, 0, ONES, "hyst lo saturate");
        addVec(0, 1, 1, 10, 20, 30, 0, "hyst hi boundary");

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].newFrame) begin
                endFrame();
                idle(40);
                bus.iTHRESH = 10'(tbl[i].thresh);
                bus.iHYST   = 10'(tbl[i].hyst);
                applyStimulus(tbl[i].mode);
            end else if (tbl[i].newLine) begin
                endLine();
            end
            bus.iTHRESH = 10'(tbl[i].thresh);
            bus.iHYST   = 10'(tbl[i].hyst);
            pixel(tbl[i].data, tbl[i].expData, tbl[i].name);
        end
        endFrame();
        idle(40);

        // Adaptive: frame mean becomes the next frame's threshold.
        doReset();
        bus.iTHRESH = 10'd500;
        bus.iHYST   = '0;
        applyStimulus(2);
        pixel(100, 0, "adapt f1 100");
        pixel(200, 0, "adapt f1 200");
        pixel(300, 0, "adapt f1 300");
        pixel(400, 0, "adapt f1 400");
        endFrame();
        firstBusy = int'(bus.oBUSY);
        busyLen = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.oBUSY) busyLen++;
            tick();
        end
        checkOutput("busy after fall", firstBusy, 1);
        checkOutput("busy length near 31", int'(busyLen >= 29 && busyLen <= 33), 1);
        checkOutput("thresh held in blanking", int'(bus.oTHRESH), 500);
        applyStimulus(2);
        checkOutput("adapt commit 250", int'(bus.oTHRESH), 250);
        pixel(251, ONES, "adapt 251");
        pixel(250, 0, "adapt 250");
        endFrame();
        idle(40);

        // Empty frame: no division, threshold unchanged.
        applyStimulus(2);
        checkOutput("thresh before empty", int'(bus.oTHRESH), 250);
        idle(5);
        endFrame();
        busyLen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.oBUSY) busyLen++;
            tick();
        end
        checkOutput("empty frame busy cycles", busyLen, 0);
        applyStimulus(2);
        checkOutput("thresh after empty", int'(bus.oTHRESH), 250);
        endFrame();
        idle(40);

        // Short blanking: result misses the next rise and lands one frame later.
        applyStimulus(2);
        pixel(600, ONES, "short f1 600");
        pixel(800, ONES, "short f1 800");
        endFrame();
        idle(4);
        checkOutput("busy at short rise", int'(bus.oBUSY), 1);
        applyStimulus(2);
        dev = 0;
        for (int i = 0; i < 50; i++) begin
            if (int'(bus.oTHRESH) != 250) dev++;
            tick();
        end
        checkOutput("thresh held whole frame", dev, 0);
        endFrame();
        idle(10);
        applyStimulus(2);
        checkOutput("late commit 700", int'(bus.oTHRESH), 700);
        endFrame();
        idle(40);

        // Reset in the middle of a division.
        applyStimulus(2);
        pixel(900, ONES, "prereset 900");
        pixel(1000, ONES, "prereset 1000");
        endFrame();
        idle(10);
        checkOutput("busy before reset", int'(bus.oBUSY), 1);
        rst_n = 1'b0;
        tick();
        checkOutput("midreset oBUSY", int'(bus.oBUSY), 0);
        checkOutput("midreset oTHRESH", int'(bus.oTHRESH), THRESH_INIT);
        checkOutput("midreset oDVAL", int'(bus.oDVAL), 0);
        rst_n = 1'b1;
        idle(40);
        applyStimulus(2);
        checkOutput("postreset thresh", int'(bus.oTHRESH), THRESH_INIT);
        pixel(100, 0, "postreset 100");
        pixel(200, 0, "postreset 200");
        pixel(300, 0, "postreset 300");
        pixel(400, 0, "postreset 400");
        endFrame();
        idle(40);
        applyStimulus(2);
        checkOutput("postreset commit 250", int'(bus.oTHRESH), 250);
        endFrame();
        idle(40);

        // Randomized frames against a frame-level reference model.
        doReset();
        thrModel = THRESH_INIT;
        for (int f = 0; f < 14; f++) begin
            m  = int'($urandom_range(0, 3));
            em = (m == 3) ? 0 : m;
            t  = int'($urandom_range(0, 1023));
            h  = int'($urandom_range(0, 200));
            bus.iTHRESH = 10'(t);
            bus.iHYST   = 10'(h);
            applyStimulus(m);
            checkOutput("rand frame thresh", int'(bus.oTHRESH), thrModel);
            fsum = 0;
            fcnt = 0;
            nLines = (f == 4) ? 0 : int'($urandom_range(1, 3));
            for (int ln = 0; ln < nLines; ln++) begin
                s = 0;
                nPix = int'($urandom_range(1, 8));
                for (int p = 0; p < nPix; p++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        d = int'($urandom_range(0, 1023));
                    end else begin
                        d = t + int'($urandom_range(0, 2 * h + 20)) - h - 10;
                        if (d < 0) d = 0;
                        if (d > 1023) d = 1023;
                    end
                    hi = (t + h > 1023) ? 1023 : t + h;
                    lo = (t - h < 0) ? 0 : t - h;
                    if (s == 0 && d > hi) s = 1;
                    else if (s == 1 && d < lo) s = 0;
                    case (em)
                        1:       e = (s == 1) ? ONES : 0;
                        2:       e = (d > thrModel) ? ONES : 0;
                        default: e = (d > t) ? ONES : 0;
                    endcase
                    pixel(d, e, "rand pixel");
                    fsum += d;
                    fcnt++;
                end
                endLine();
            end
            endFrame();
            idle(40);
            if (fcnt > 0) thrModel = fsum / fcnt;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_binarize_adaptive.md
Name: gray_binarize_adaptive

Overview:
- Parametrised successor to the fixed-threshold gray-to-binary stage in the capture pipeline.
- Sits between the grayscale converter and the display/storage path.
- Three selectable modes: fixed threshold, hysteresis threshold, and adaptive threshold, where the adaptive threshold is the mean gray level of the previous frame.
- The frame mean is computed during vertical blanking by a sequential divider.

Parameters:
- DATA_W, 10, pixel width; the binary "1" output is 2^DATA_W-1.
- CNT_W, 20, pixel-counter width; max frame size is 2^CNT_W-1 pixels.
- THRESH_INIT, 500, adaptive threshold after reset.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  reset; asynchronous, active-low.
- iFVAL  in  1  frame valid, high for the whole active frame.
- iDVAL  in  1  pixel valid (line valid qualified).
- iDATA  in  DATA_W  gray pixel, unsigned.
- iMODE  in  2  0=fixed, 1=hysteresis, 2=adaptive, 3=treated as 0.
- iTHRESH  in  DATA_W  fixed/centre threshold.
- iHYST  in  DATA_W  hysteresis half-band.
- oDVAL  out  1  output pixel valid.
- oDATA  out  DATA_W  0 or all-ones.
- oTHRESH  out  DATA_W  adaptive threshold currently in force.
- oBUSY  out  1  mean divider running.

Behaviour:
- Reset (async, iRST=0):
  - oDVAL=0, oDATA=0, oBUSY=0, oTHRESH=THRESH_INIT.
  - Accumulators, pending result and hysteresis state cleared.
  - Divider FSM returns to IDLE.
  - Mode register = 0.
- Latency: oDVAL = iDVAL delayed exactly 1 cycle. oDATA is registered on every cycle and only meaningful while oDVAL=1.
- Mode capture: iMODE is sampled into the mode register on the iFVAL rising edge and held for the frame. iMODE changes mid-frame have no effect.
- Fixed mode: oDATA = all-ones if iDATA > iTHRESH, else 0 (strict greater-than).
- Hysteresis mode:
  - Per-line state bit s, cleared on each iDVAL rising edge.
  - hi = min(iTHRESH+iHYST, 2^DATA_W-1); lo = max(iTHRESH-iHYST, 0). Both saturate; no wrap.
  - If s=0: s becomes 1 when iDATA > hi.
  - If s=1: s becomes 0 when iDATA < lo.
  - oDATA reflects the updated s for that pixel.
- Adaptive mode: oDATA = all-ones if iDATA > oTHRESH, else 0.
- Accumulation (runs in all modes):
  - On each cycle with iFVAL & iDVAL: sum += iDATA (sum width DATA_W+CNT_W), cnt += 1.
  - Once cnt reaches 2^CNT_W-1, both freeze for the rest of the frame; no wrap.
  - sum and cnt clear on the iFVAL rising edge.
- Divider FSM (sub-module), states IDLE, LOAD, DIV, DONE:
  - iFVAL falling edge in IDLE: LOAD latches sum/cnt and clears the accumulators.
  - If cnt=0, go straight to IDLE with no result (threshold held).
  - DIV: restoring division, one quotient bit per cycle, DATA_W+CNT_W cycles. oBUSY=1 from LOAD through DIV.
  - DONE: quotient truncated (floor) into pending register, pending_valid=1, then IDLE.
  - A falling edge while not IDLE is ignored; it cannot occur with legal framing.
- Commit:
  - On the iFVAL rising edge with pending_valid=1: oTHRESH <= pending, pending_valid <= 0.
  - If the divider is still busy at the rising edge, oTHRESH is unchanged for that whole frame. The result commits at the next rising edge.
  - oTHRESH never changes mid-frame.
- Reset mid-division: divider aborts, pending discarded, oTHRESH = THRESH_INIT.

Decomposition:
- Package gray_bin_pkg:
  - Mode constants MODE_FIXED=0, MODE_HYST=1, MODE_ADAPT=2.
  - Divider state encoding.
  - Width helper SUM_W = DATA_W+CNT_W.
- Sub-module: seq_divider_u (unsigned restoring divider).
  - Parameters: dividend width, divisor width.
  - Handshake: start/busy/done.
  - Async active-low reset on iRST.

Test Plan:
- Fixed, iTHRESH=500: iDATA 499, 500, 501, 1023 → oDATA 0, 0, 1023, 1023, each one cycle after iDVAL; oDVAL tracks iDVAL delayed by 1.
- Hysteresis, iTHRESH=500, iHYST=20, one line: 515, 521, 490, 481, 479, 521 → 0, 1023, 1023, 1023, 0, 1023. New line starting with 510 → 0 (state cleared).
- Adaptive:
  - Frame 1 pixels 100, 200, 300, 400 → oBUSY high ~30 cycles after iFVAL fall.
  - At the next iFVAL rise, oTHRESH=250.
  - Frame 2 pixels 251, 250 → 1023, 0.
- Empty frame (iFVAL pulse, no iDVAL) → no division, oBUSY stays 0, oTHRESH unchanged.
- Short blanking: iFVAL rise 5 cycles after fall (divider busy) → oTHRESH holds the old value for the entire frame; the new mean appears at the following rise.
- Reset mid-DIV: iRST low for 1 cycle → oBUSY=0, oTHRESH=500, oDVAL=0. The next full frame is processed normally.
